// File: rtl/jam_pkg.sv
// JAM cost-lookup shared definitions.
// Used by the cost server and the assignment solver.
package jam_pkg;

  localparam int COST_W = 7;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 2 * IDX_W;
  localparam int N_ENT  = 1 << ADDR_W;
  localparam int SUM_W  = 13;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } jam_state_e;

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost register file.
// One write port, one combinational read port.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem_q [N_ENT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/jam_cost_server.sv
// JAM cost-table responder: streams the table in,
// serves (W,J) lookups, captures the solver result.
module jam_cost_server
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              restart,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [9:0]        MinCost,
  input  logic [3:0]        MatchCount,
  output logic              table_ready,
  output logic [SUM_W-1:0]  checksum,
  output logic [15:0]       query_cnt,
  output logic [9:0]        res_min,
  output logic [3:0]        res_cnt,
  output logic              done
);

  jam_state_e        state_q;
  logic [ADDR_W-1:0] load_cnt_q;
  logic [SUM_W-1:0]  checksum_q;
  logic [15:0]       query_cnt_q;
  logic [9:0]        res_min_q;
  logic [3:0]        res_cnt_q;
  logic              done_q;
  logic              table_ready_q;
  logic              in_ready_q;
  logic              valid_q;
  logic              accept;
  logic              vld_rise;
  logic [COST_W-1:0] rdata;

  assign accept   = in_valid && in_ready_q;
  assign vld_rise = Valid && !valid_q;

  jam_cost_table u_tbl (
    .clk   (CLK),
    .rst   (RST),
    .we    (accept),
    .waddr (load_cnt_q),
    .wdata (in_data),
    .raddr ({W, J}),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= LOAD;
      load_cnt_q    <= '0;
      checksum_q    <= '0;
      query_cnt_q   <= '0;
      res_min_q     <= '0;
      res_cnt_q     <= '0;
      done_q        <= 1'b0;
      table_ready_q <= 1'b0;
      in_ready_q    <= 1'b1;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= Valid;
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            checksum_q <= checksum_q
              + {{(SUM_W-COST_W){1'b0}}, in_data};
            load_cnt_q <= load_cnt_q + 1'b1;
            if (load_cnt_q == ADDR_W'(N_ENT - 1)) begin
              state_q       <= SERVE;
              table_ready_q <= 1'b1;
              in_ready_q    <= 1'b0;
            end
          end
        end
        SERVE, DONE: begin
          // restart beats a coincident Valid edge
          if (restart) begin
            state_q       <= LOAD;
            load_cnt_q    <= '0;
            checksum_q    <= '0;
            query_cnt_q   <= '0;
            done_q        <= 1'b0;
            table_ready_q <= 1'b0;
            in_ready_q    <= 1'b1;
          end else if (state_q == SERVE) begin
            if (query_cnt_q != 16'hFFFF) begin
              query_cnt_q <= query_cnt_q + 16'd1;
            end
            if (vld_rise) begin
              res_min_q <= MinCost;
              res_cnt_q <= MatchCount;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign table_ready = table_ready_q;
  assign checksum    = checksum_q;
  assign query_cnt   = query_cnt_q;
  assign res_min     = res_min_q;
  assign res_cnt     = res_cnt_q;
  assign done        = done_q;
  assign Cost        = table_ready_q ? rdata : '0;

endmodule

// File: tb/tb_jam_cost_server.sv
// Randomized bench for jam_cost_server against
// a table/counter model of the lookup protocol.
module tb_jam_cost_server;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic       restart;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  logic       table_ready;
  logic [12:0] checksum;
  logic [15:0] query_cnt;
  logic [9:0] res_min;
  logic [3:0] res_cnt;
  logic       done;

  int total = 0;
  int bad   = 0;
  int mdl [64];
  int srv   = 0;
  bit in_srv = 0;
  int sum;
  int mc, cc;

  always #5 CLK = ~CLK;

  jam_cost_server dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .Valid      (Valid),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .table_ready(table_ready),
    .checksum   (checksum),
    .query_cnt  (query_cnt),
    .res_min    (res_min),
    .res_cnt    (res_cnt),
    .done       (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
    if (in_srv) srv++;
  endtask

  task automatic look(input int w, input int j);
    W = 3'(w);
    J = 3'(j);
    #1;
    chk("cost", Cost, mdl[w*8+j]);
  endtask

  task automatic load_tbl(input bit gaps, input bit rp);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      in_valid = 1'b1;
      in_data  = 7'(mdl[i]);
      restart  = rp && (i == 30);
      tick();
      restart  = 1'b0;
      if (i == 62) chk("tr_early", table_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 0; in_data = 0; restart = 0;
    W = 0; J = 0; Valid = 0; MinCost = 0; MatchCount = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_tr", table_ready, 0);
    chk("rst_sum", checksum, 0);
    chk("rst_qc", query_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_min", res_min, 0);
    chk("rst_cnt", res_cnt, 0);
    chk("rst_cost", Cost, 0);
    RST = 1'b0;

    // partial random load, then async reset
    sum = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      in_valid = 1'b1;
      in_data  = 7'($urandom_range(0, 127));
      sum += in_data;
      tick();
    end
    in_valid = 1'b0;
    chk("part_sum", checksum, sum);
    #2 RST = 1'b1;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_sum", checksum, 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // ramp load with in_valid held high
    for (int i = 0; i < 64; i++) mdl[i] = i;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 7'(i);
      if (i == 18) begin
        W = 3'd2; J = 3'd2;
        #1 chk("cost_early", Cost, 0);
      end
      tick();
      if (i == 62) chk("tr_at63", table_ready, 0);
    end
    chk("tr_at64", table_ready, 1);
    chk("ramp_sum", checksum, 2016);
    chk("srv_ready", in_ready, 0);
    in_srv = 1; srv = 0;

    W = 3; J = 5; #1 chk("c35", Cost, 29);
    W = 7; J = 7; #1 chk("c77", Cost, 63);
    W = 0; J = 0; #1 chk("c00", Cost, 0);
    for (int i = 0; i < 20; i++) begin
      in_data = 7'($urandom);
      look($urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0;
    chk("srv_sum", checksum, 2016);
    chk("srv_qc", query_cnt, srv);

    MinCost = 10'd214; MatchCount = 4'd2; Valid = 1'b1;
    tick();
    in_srv = 0;
    chk("cap_done", done, 1);
    chk("cap_min", res_min, 214);
    chk("cap_cnt", res_cnt, 2);
    chk("cap_qc", query_cnt, srv);
    MinCost = 10'd100; Valid = 1'b0;
    tick();
    Valid = 1'b1;
    repeat (2) tick();
    chk("hold_min", res_min, 214);
    chk("hold_qc", query_cnt, srv);
    look($urandom_range(0, 7), $urandom_range(0, 7));

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_ready", in_ready, 1);
    chk("rs_tr", table_ready, 0);
    chk("rs_done", done, 0);
    chk("rs_sum", checksum, 0);
    chk("rs_qc", query_cnt, 0);
    chk("rs_min", res_min, 214);
    chk("rs_cnt", res_cnt, 2);
    chk("rs_cost", Cost, 0);

    for (int i = 0; i < 64; i++) mdl[i] = 127;
    load_tbl(1, 1);
    chk("max_sum", checksum, 8128);
    chk("max_tr", table_ready, 1);
    in_srv = 1; srv = 0;
    MinCost = 10'd77;
    repeat (3) tick();
    chk("lvl_nocap", done, 0);
    chk("lvl_qc", query_cnt, srv);
    look($urandom_range(0, 7), $urandom_range(0, 7));

    Valid = 1'b0;
    tick();
    in_srv = 0;
    Valid = 1'b1; restart = 1'b1; MinCost = 10'd55;
    tick();
    restart = 1'b0;
    chk("race_done", done, 0);
    chk("race_ready", in_ready, 1);
    chk("race_min", res_min, 214);
    chk("race_qc", query_cnt, 0);

    sum = 0;
    for (int i = 0; i < 64; i++) begin
      mdl[i] = $urandom_range(0, 127);
      sum += mdl[i];
    end
    load_tbl(1, 0);
    chk("rnd_sum", checksum, sum);
    in_srv = 1; srv = 0;
    for (int i = 0; i < 16; i++) begin
      look($urandom_range(0, 7), $urandom_range(0, 7));
      tick();
    end
    Valid = 1'b0;
    tick();
    mc = $urandom_range(0, 1023);
    cc = $urandom_range(0, 15);
    MinCost = 10'(mc); MatchCount = 4'(cc); Valid = 1'b1;
    tick();
    in_srv = 0;
    chk("rnd_done", done, 1);
    chk("rnd_min", res_min, mc);
    chk("rnd_cnt", res_cnt, cc);
    chk("rnd_qc", query_cnt, srv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
